// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide data memory.
// Sub-word stores are done as read-modify-write, one request in flight.
module load_store_unit #(
    parameter int MEM_ADDR_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]            state;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [MEM_ADDR_W+1:0] addr_q;
    logic [15:0]           wdata_q;
    logic [31:0]           word_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic                  bad;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [31:0]           load_data;
    logic [31:0]           merged;
    logic                  unused;

    // Address bits above the memory window alias back into it.
    assign unused = ^req_addr[31:MEM_ADDR_W+2];

    always_comb begin
        bad = 1'b0;
        if (req_we) begin
            unique case (req_funct3)
                3'b000:  bad = 1'b0;
                3'b001:  bad = req_addr[0];
                3'b010:  bad = |req_addr[1:0];
                default: bad = 1'b1;
            endcase
        end else begin
            unique case (req_funct3)
                3'b000, 3'b100: bad = 1'b0;
                3'b001, 3'b101: bad = req_addr[0];
                3'b010:         bad = |req_addr[1:0];
                default:        bad = 1'b1;
            endcase
        end
    end

    always_comb begin
        lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (f3_q)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_data = {24'b0, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_data = {16'b0, lane_h};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (f3_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= '0;
            wdata_q <= 16'b0;
            word_q  <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    rdata_q <= 32'b0;
                    err_q   <= 1'b0;
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr[MEM_ADDR_W+1:0];
                        wdata_q <= req_wdata[15:0];
                        if (bad) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else if (req_we && req_funct3 == 3'b010) begin
                            word_q <= req_wdata;
                            state  <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        word_q <= merged;
                        state  <= WRITE;
                    end else begin
                        rdata_q <= load_data;
                        state   <= RESP;
                    end
                end
                WRITE: state <= RESP;
                RESP: begin
                    rdata_q <= 32'b0;
                    err_q   <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_we     = (state == WRITE);
    assign mem_addr   = {{(32-MEM_ADDR_W){1'b0}}, addr_q[MEM_ADDR_W+1:2]};
    assign mem_wdata  = word_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int rv_cnt = 0;
    int acc_cnt = 0;
    logic [31:0] last_rdata = 32'b0;

    load_store_unit #(.MEM_ADDR_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (req_valid && req_ready && !reset) acc_cnt++;
    end

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (resp_valid) begin
            rv_cnt++;
            last_rdata = resp_rdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic we,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input int exp_lat,
                           input int exp_we);
        int lat;
        int we0;
        @(negedge clk);
        we0 = we_cnt;
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        chk({tag, "_addr"}, mem_addr, 32'd4);
        while (!resp_valid && lat < 8) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rdata"}, resp_rdata, exp_rd);
        chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
        @(posedge clk);
        #1;
        chk({tag, "_we"}, we_cnt - we0, exp_we);
        chk({tag, "_idle"}, {resp_valid, req_ready, resp_err}, 3'b010);
    endtask

    initial begin
        int rv0;
        int acc0;
        int we0;
        for (int i = 0; i < 256; i++) mem[i] = 32'b0;
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp", {resp_valid, resp_err, mem_we}, 3'b000);
        chk("rst_rdata", resp_rdata, 32'b0);
        chk("rst_maddr", mem_addr, 32'b0);
        chk("rst_mwdata", mem_wdata, 32'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_req("sw", 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 2, 1);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        run_req("lw", 0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0, 2, 0);
        run_req("sb", 1, 3'b000, 32'h11, 32'h000000AA, 0, 0, 3, 1);
        chk("sb_mem", mem[4], 32'hDEADAAEF);
        run_req("lb", 0, 3'b000, 32'h11, 0, 32'hFFFFFFAA, 0, 2, 0);
        run_req("lbu", 0, 3'b100, 32'h11, 0, 32'h000000AA, 0, 2, 0);
        run_req("sh", 1, 3'b001, 32'h12, 32'h00001234, 0, 0, 3, 1);
        chk("sh_mem", mem[4], 32'h1234AAEF);
        run_req("lh12", 0, 3'b001, 32'h12, 0, 32'h00001234, 0, 2, 0);
        run_req("lhu10", 0, 3'b101, 32'h10, 0, 32'h0000AAEF, 0, 2, 0);
        run_req("lh10", 0, 3'b001, 32'h10, 0, 32'hFFFFAAEF, 0, 2, 0);
        run_req("lb13", 0, 3'b000, 32'h13, 0, 32'h00000012, 0, 2, 0);
        run_req("lbu12", 0, 3'b100, 32'h12, 0, 32'h00000034, 0, 2, 0);

        run_req("lw_mis", 0, 3'b010, 32'h13, 0, 0, 1, 1, 0);
        run_req("sh_mis", 1, 3'b001, 32'h11, 32'hFFFF, 0, 1, 1, 0);
        run_req("ld_011", 0, 3'b011, 32'h10, 0, 0, 1, 1, 0);
        run_req("st_100", 1, 3'b100, 32'h10, 32'h55, 0, 1, 1, 0);
        chk("err_mem", mem[4], 32'h1234AAEF);

        @(negedge clk);
        rv0 = rv_cnt;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b000;
        req_addr = 32'h11;
        req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 chk("rst_in_write", {31'b0, mem_we}, 32'd1);
        reset = 1'b1;
        #1 chk("rst_we_drop", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready2", {31'b0, req_ready}, 32'd1);
        chk("rst_mem", mem[4], 32'h1234AAEF);
        chk("rst_no_resp", rv_cnt - rv0, 0);

        @(negedge clk);
        rv0 = rv_cnt;
        acc0 = acc_cnt;
        we0 = we_cnt;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h0004_0010;
        repeat (9) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_acc", acc_cnt - acc0, 3);
        chk("b2b_resp", rv_cnt - rv0, 3);
        chk("b2b_rdata", last_rdata, 32'h1234AAEF);
        chk("b2b_addr", mem_addr, 32'd4);
        chk("b2b_we", we_cnt - we0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
